// File: rtl/regfile_bus_arbiter_if.sv
// Signal bundle between the register-bus arbiter, its requesters and the register file.
// The master side is the arbiter; the slave side is everything it serves or drives.
interface regfile_bus_arbiter_if #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 6
);
  logic [NUM_REQ-1:0]            req_valid;
  logic [2*NUM_REQ-1:0]          req_op;
  logic [ADDR_WIDTH*NUM_REQ-1:0] req_src;
  logic [ADDR_WIDTH*NUM_REQ-1:0] req_dst;
  logic [DATA_WIDTH*NUM_REQ-1:0] req_imm;
  logic [NUM_REQ-1:0]            req_ready;
  logic [NUM_REQ-1:0]            resp_valid;
  logic [DATA_WIDTH-1:0]         resp_data;
  logic                          resp_err;
  logic [ADDR_WIDTH-1:0]         register_addr;
  logic                          bus_register_out_en;
  logic                          bus_register_input_en;
  logic [DATA_WIDTH-1:0]         bus_data_in;
  logic [DATA_WIDTH-1:0]         bus_data_out;
  logic                          bus_data_out_en;
  logic                          busy;

  modport master (
    input  req_valid, req_op, req_src, req_dst, req_imm, bus_data_in,
    output req_ready, resp_valid, resp_data, resp_err, register_addr,
           bus_register_out_en, bus_register_input_en, bus_data_out,
           bus_data_out_en, busy
  );

  modport slave (
    output req_valid, req_op, req_src, req_dst, req_imm, bus_data_in,
    input  req_ready, resp_valid, resp_data, resp_err, register_addr,
           bus_register_out_en, bus_register_input_en, bus_data_out,
           bus_data_out_en, busy
  );
endinterface

// File: rtl/regfile_bus_arbiter.sv
// Round-robin arbiter for the shared register bus: grants one requester at a time and
// splits its MOVE/LOAD/READ into single-address read and write phases.
module regfile_bus_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 6
) (
  input  logic                 arbiter_clock,
  input  logic                 arbiter_reset,
  regfile_bus_arbiter_if.master bus
);
  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [1:0] OP_MOVE = 2'b00;
  localparam logic [1:0] OP_LOAD = 2'b01;
  localparam logic [1:0] OP_READ = 2'b10;
  localparam logic [1:0] OP_RSVD = 2'b11;

  typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

  state_t                state, state_nxt;
  logic [PTR_W-1:0]      rr_ptr, grant, pick;
  logic                  pick_found;
  logic [1:0]            op_q;
  logic [ADDR_WIDTH-1:0] src_q, dst_q;
  logic [DATA_WIDTH-1:0] hold, resp_data_q;
  logic                  err_q;

  logic [1:0]            op_arr  [NUM_REQ];
  logic [ADDR_WIDTH-1:0] src_arr [NUM_REQ];
  logic [ADDR_WIDTH-1:0] dst_arr [NUM_REQ];
  logic [DATA_WIDTH-1:0] imm_arr [NUM_REQ];

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign op_arr[i]  = bus.req_op[2*i +: 2];
    assign src_arr[i] = bus.req_src[ADDR_WIDTH*i +: ADDR_WIDTH];
    assign dst_arr[i] = bus.req_dst[ADDR_WIDTH*i +: ADDR_WIDTH];
    assign imm_arr[i] = bus.req_imm[DATA_WIDTH*i +: DATA_WIDTH];
  end

  function automatic logic [PTR_W-1:0] wrap_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(NUM_REQ - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // First pending requester at or after rr_ptr, wrapping modulo NUM_REQ.
  always_comb begin
    logic [PTR_W:0] idx;
    pick_found = 1'b0;
    pick       = rr_ptr;
    idx        = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = {1'b0, rr_ptr} + (PTR_W+1)'(i);
      if (idx >= (PTR_W+1)'(NUM_REQ)) idx = idx - (PTR_W+1)'(NUM_REQ);
      if (!pick_found && bus.req_valid[idx[PTR_W-1:0]]) begin
        pick_found = 1'b1;
        pick       = idx[PTR_W-1:0];
      end
    end
  end

  always_ff @(posedge arbiter_clock or negedge arbiter_reset) begin
    if (!arbiter_reset) state <= IDLE;
    else                state <= state_nxt;
  end

  always_comb begin
    state_nxt                 = state;
    bus.req_ready             = '0;
    bus.resp_valid            = '0;
    bus.resp_err              = 1'b0;
    bus.register_addr         = '0;
    bus.bus_register_out_en   = 1'b0;
    bus.bus_register_input_en = 1'b0;
    bus.bus_data_out          = '0;
    bus.bus_data_out_en       = 1'b0;
    case (state)
      IDLE: begin
        // Gating with reset keeps an asserted req_valid from looking accepted while held in reset.
        if (pick_found && arbiter_reset) begin
          bus.req_ready[pick] = 1'b1;
          case (op_arr[pick])
            OP_MOVE, OP_READ: state_nxt = READ;
            OP_LOAD:          state_nxt = WRITE;
            default:          state_nxt = RESP;
          endcase
        end
      end
      READ: begin
        bus.register_addr       = src_q;
        bus.bus_register_out_en = 1'b1;
        state_nxt               = (op_q == OP_MOVE) ? WRITE : RESP;
      end
      WRITE: begin
        bus.register_addr         = dst_q;
        bus.bus_data_out          = hold;
        bus.bus_data_out_en       = 1'b1;
        bus.bus_register_input_en = 1'b1;
        state_nxt                 = RESP;
      end
      RESP: begin
        bus.resp_valid[grant] = 1'b1;
        bus.resp_err          = err_q;
        state_nxt             = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge arbiter_clock or negedge arbiter_reset) begin
    if (!arbiter_reset) begin
      rr_ptr      <= '0;
      grant       <= '0;
      op_q        <= '0;
      src_q       <= '0;
      dst_q       <= '0;
      hold        <= '0;
      err_q       <= 1'b0;
      resp_data_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_found) begin
            grant  <= pick;
            rr_ptr <= wrap_inc(pick);
            op_q   <= op_arr[pick];
            src_q  <= src_arr[pick];
            dst_q  <= dst_arr[pick];
            hold   <= (op_arr[pick] == OP_LOAD) ? imm_arr[pick] : '0;
            err_q  <= (op_arr[pick] == OP_RSVD);
          end
        end
        READ: hold        <= bus.bus_data_in;
        RESP: resp_data_q <= hold;
        default: ;
      endcase
    end
  end

  // resp_data shows the live result during RESP and keeps it until the next one.
  assign bus.resp_data = (state == RESP) ? hold : resp_data_q;
  assign bus.busy      = (state != IDLE);
endmodule

// File: tb/tb_regfile_bus_arbiter.sv
// Bench for regfile_bus_arbiter: directed vector table, reset/round-robin sequences and
// random traffic against a transaction-level model with a 4-entry register file.
module tb_regfile_bus_arbiter;
  localparam int N  = 4;
  localparam int DW = 16;
  localparam int AW = 6;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  regfile_bus_arbiter_if #(.NUM_REQ(N), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();
  regfile_bus_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .arbiter_clock(clk),
    .arbiter_reset(rst_n),
    .bus(bus)
  );

  // Register file: addresses above 3 are not decoded.
  logic [DW-1:0] rf [4];
  logic          rf_clear;
  always_ff @(posedge clk) begin
    if (rf_clear) begin
      for (int i = 0; i < 4; i++) rf[i] <= '0;
    end else if (bus.bus_register_input_en && bus.register_addr[AW-1:2] == '0) begin
      rf[bus.register_addr[1:0]] <= bus.bus_data_out;
    end
  end
  assign bus.bus_data_in = (bus.bus_register_out_en && bus.register_addr[AW-1:2] == '0)
                           ? rf[bus.register_addr[1:0]] : '0;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual=%0h expected=%0h", nm, act, exp);
  endtask

  task automatic fail_bound(input string nm);
    n_checks++;
    $display("FAIL %s: actual=timeout expected=event within bound", nm);
  endtask

  logic [1:0]    r_op  [N];
  logic [AW-1:0] r_src [N];
  logic [AW-1:0] r_dst [N];
  logic [DW-1:0] r_imm [N];

  task automatic drive_fields();
    for (int i = 0; i < N; i++) begin
      bus.req_op[2*i +: 2]    = r_op[i];
      bus.req_src[AW*i +: AW] = r_src[i];
      bus.req_dst[AW*i +: AW] = r_dst[i];
      bus.req_imm[DW*i +: DW] = r_imm[i];
    end
  endtask

  function automatic logic [63:0] pack_out(input logic [AW-1:0] a, input logic oe, input logic ie,
                                           input logic doe, input logic [DW-1:0] bdo,
                                           input logic [N-1:0] rv, input logic err,
                                           input logic [DW-1:0] rd, input logic bsy);
    return {17'd0, bsy, a, oe, ie, doe, bdo, rv, err, rd};
  endfunction

  function automatic logic [63:0] dut_out();
    return pack_out(bus.register_addr, bus.bus_register_out_en, bus.bus_register_input_en,
                    bus.bus_data_out_en, bus.bus_data_out, bus.resp_valid, bus.resp_err,
                    bus.resp_data, bus.busy);
  endfunction

  typedef struct {
    int            req;
    logic [1:0]    op;
    logic [AW-1:0] src;
    logic [AW-1:0] dst;
    logic [DW-1:0] imm;
    logic [DW-1:0] exp_data;
    logic          exp_err;
  } vec_t;

  vec_t          vecs [11];
  logic [DW-1:0] last_resp;

  task automatic run_vec(input int id, input vec_t v);
    logic [N-1:0] rv1;
    logic [63:0]  exp;
    int           nph;
    rv1 = '0;
    rv1[v.req] = 1'b1;
    @(posedge clk); #1;
    r_op[v.req] = v.op; r_src[v.req] = v.src; r_dst[v.req] = v.dst; r_imm[v.req] = v.imm;
    drive_fields();
    bus.req_valid = rv1;
    @(negedge clk);
    check($sformatf("vec%0d_ready", id), 64'(bus.req_ready), 64'(rv1));
    @(posedge clk); #1;
    bus.req_valid = '0;
    nph = (v.op == 2'b00) ? 3 : (v.op == 2'b11) ? 1 : 2;
    for (int p = 0; p < nph; p++) begin
      @(negedge clk);
      if (p == nph - 1)
        exp = pack_out('0, 1'b0, 1'b0, 1'b0, '0, rv1, v.exp_err, v.exp_data, 1'b1);
      else if (v.op == 2'b10 || (v.op == 2'b00 && p == 0))
        exp = pack_out(v.src, 1'b1, 1'b0, 1'b0, '0, '0, 1'b0, last_resp, 1'b1);
      else
        exp = pack_out(v.dst, 1'b0, 1'b1, 1'b1, v.exp_data, '0, 1'b0, last_resp, 1'b1);
      check($sformatf("vec%0d_phase%0d", id, p), dut_out(), exp);
    end
    last_resp = v.exp_data;
    @(negedge clk);
    check($sformatf("vec%0d_idle", id), dut_out(),
          pack_out('0, 1'b0, 1'b0, 1'b0, '0, '0, 1'b0, last_resp, 1'b0));
  endtask

  // Transaction-level model state for random traffic.
  logic [DW-1:0] model_rf [4];
  int            model_rr;
  bit            inflight;
  int            ex_idx, ex_lat, ex_cyc;
  logic [DW-1:0] ex_data;
  logic          ex_err;
  int            n_acc, n_resp;

  function automatic int model_pick(input logic [N-1:0] v, input int rr);
    for (int k = 0; k < N; k++) if (v[(rr + k) % N]) return (rr + k) % N;
    return -1;
  endfunction

  function automatic logic [DW-1:0] model_rd(input logic [AW-1:0] a);
    return (a < 4) ? model_rf[a[1:0]] : '0;
  endfunction

  task automatic new_req(input int i);
    r_op[i]  = 2'($urandom_range(0, 3));
    r_src[i] = AW'($urandom_range(0, 7));
    r_dst[i] = AW'($urandom_range(0, 7));
    r_imm[i] = DW'($urandom);
    bus.req_valid[i] = 1'($urandom_range(0, 1));
  endtask

  initial begin
    logic [N-1:0] exp_rdy, exp_rv;
    int           g, acc;
    bit           got;

    vecs[0]  = '{0, 2'b01, 6'd0, 6'd2, 16'hBEEF, 16'hBEEF, 1'b0};
    vecs[1]  = '{1, 2'b00, 6'd2, 6'd3, 16'h0000, 16'hBEEF, 1'b0};
    vecs[2]  = '{2, 2'b10, 6'd3, 6'd0, 16'h0000, 16'hBEEF, 1'b0};
    vecs[3]  = '{3, 2'b11, 6'd1, 6'd1, 16'h1111, 16'h0000, 1'b1};
    vecs[4]  = '{1, 2'b01, 6'd0, 6'd5, 16'h1234, 16'h1234, 1'b0};
    vecs[5]  = '{0, 2'b10, 6'd5, 6'd0, 16'h0000, 16'h0000, 1'b0};
    vecs[6]  = '{2, 2'b01, 6'd0, 6'd0, 16'h0A5A, 16'h0A5A, 1'b0};
    vecs[7]  = '{3, 2'b00, 6'd0, 6'd1, 16'h0000, 16'h0A5A, 1'b0};
    vecs[8]  = '{0, 2'b10, 6'd1, 6'd0, 16'h0000, 16'h0A5A, 1'b0};
    vecs[9]  = '{2, 2'b00, 6'd6, 6'd0, 16'h0000, 16'h0000, 1'b0};
    vecs[10] = '{1, 2'b10, 6'd0, 6'd0, 16'h0000, 16'h0000, 1'b0};

    rf_clear = 1'b1;
    for (int i = 0; i < N; i++) begin r_op[i] = '0; r_src[i] = '0; r_dst[i] = '0; r_imm[i] = '0; end
    drive_fields();
    bus.req_valid = '1;
    @(negedge clk);
    check("reset_outputs", dut_out(), 64'd0);
    check("reset_ready", 64'(bus.req_ready), 64'd0);
    bus.req_valid = '0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    rf_clear = 1'b0;
    last_resp = '0;

    foreach (vecs[i]) run_vec(i, vecs[i]);

    // Reset asserted between clock edges during a WRITE phase.
    @(posedge clk); #1;
    r_op[0] = 2'b01; r_dst[0] = 6'd1; r_imm[0] = 16'h7777;
    drive_fields();
    bus.req_valid = 4'b0001;
    @(negedge clk);
    check("rstw_ready", 64'(bus.req_ready), 64'b0001);
    @(posedge clk); #1;
    bus.req_valid = '0;
    @(negedge clk);
    check("rstw_in_write", 64'({bus.bus_register_input_en, bus.bus_data_out_en, bus.register_addr}),
          64'({1'b1, 1'b1, 6'd1}));
    #2 rst_n = 1'b0;
    #1;
    check("rstw_async_drop", 64'({bus.bus_register_input_en, bus.bus_data_out_en,
                                  bus.bus_register_out_en, bus.busy}), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check($sformatf("rstw_quiet%0d", c), 64'({bus.resp_valid, bus.busy}), 64'd0);
    end
    check("rstw_resp_data", 64'(bus.resp_data), 64'd0);
    check("rstw_no_write", 64'(rf[1]), 64'h0A5A);
    last_resp = '0;

    // Round-robin with all requesters held; first grant also shows rr_ptr was reset.
    for (int i = 0; i < N; i++) begin r_op[i] = 2'b10; r_src[i] = '0; r_dst[i] = '0; r_imm[i] = '0; end
    drive_fields();
    @(posedge clk); #1;
    bus.req_valid = '1;
    for (int k = 0; k < 8; k++) begin
      got = 1'b0;
      for (int w = 0; w < 8 && !got; w++) begin
        @(negedge clk);
        if (bus.req_ready != '0) got = 1'b1;
      end
      if (!got) fail_bound($sformatf("rr_wait%0d", k));
      else begin
        exp_rdy = '0;
        exp_rdy[k % N] = 1'b1;
        check($sformatf("rr_order%0d", k), 64'(bus.req_ready), 64'(exp_rdy));
      end
    end
    @(posedge clk); #1;
    bus.req_valid = '0;
    repeat (3) @(negedge clk);
    run_vec(11, '{1, 2'b10, 6'd2, 6'd0, 16'h0000, 16'hBEEF, 1'b0});
    r_op[0] = 2'b10; r_src[0] = '0; r_op[1] = 2'b10; r_src[1] = '0;
    drive_fields();
    @(posedge clk); #1;
    bus.req_valid = 4'b0011;
    @(negedge clk);
    check("rr_wrap_from2", 64'(bus.req_ready), 64'b0001);
    @(posedge clk); #1;
    bus.req_valid = '0;
    repeat (3) @(negedge clk);

    // Random traffic against the transaction model.
    rst_n = 1'b0;
    rf_clear = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    rf_clear = 1'b0;
    for (int i = 0; i < 4; i++) model_rf[i] = '0;
    model_rr = 0; inflight = 1'b0; n_acc = 0; n_resp = 0;
    ex_idx = 0; ex_lat = 0; ex_cyc = 0; ex_data = '0; ex_err = 1'b0;
    for (int i = 0; i < N; i++) new_req(i);
    drive_fields();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      check("inv_out_en_excl", 64'(bus.bus_register_out_en & bus.bus_data_out_en), 64'd0);
      check("inv_in_en_needs_drive", 64'(bus.bus_register_input_en & ~bus.bus_data_out_en), 64'd0);
      acc = -1;
      if (bus.req_ready != '0) begin
        g = model_pick(bus.req_valid, model_rr);
        exp_rdy = '0;
        if (g >= 0) exp_rdy[g] = 1'b1;
        check("rnd_grant", 64'(bus.req_ready), 64'(exp_rdy));
        check("rnd_grant_when_free", 64'(inflight), 64'd0);
        if (g >= 0) begin
          ex_idx = g; ex_cyc = cyc; ex_err = 1'b0;
          case (r_op[g])
            2'b00: begin
              ex_data = model_rd(r_src[g]); ex_lat = 3;
              if (r_dst[g] < 4) model_rf[r_dst[g][1:0]] = ex_data;
            end
            2'b01: begin
              ex_data = r_imm[g]; ex_lat = 2;
              if (r_dst[g] < 4) model_rf[r_dst[g][1:0]] = ex_data;
            end
            2'b10: begin ex_data = model_rd(r_src[g]); ex_lat = 2; end
            default: begin ex_data = '0; ex_err = 1'b1; ex_lat = 1; end
          endcase
          model_rr = (g + 1) % N;
          inflight = 1'b1;
          n_acc++;
          acc = g;
        end
      end
      if (bus.resp_valid != '0) begin
        exp_rv = '0;
        exp_rv[ex_idx] = 1'b1;
        check("rnd_resp_idx", 64'(bus.resp_valid), 64'(exp_rv));
        check("rnd_resp_expected", 64'(inflight), 64'd1);
        check("rnd_resp_latency", 64'(cyc - ex_cyc), 64'(ex_lat));
        check("rnd_resp_data", 64'(bus.resp_data), 64'(ex_data));
        check("rnd_resp_err", 64'(bus.resp_err), 64'(ex_err));
        inflight = 1'b0;
        n_resp++;
      end else if (inflight && cyc - ex_cyc >= ex_lat) begin
        fail_bound("rnd_resp_missing");
        inflight = 1'b0;
      end
      @(posedge clk); #1;
      if (acc >= 0) new_req(acc);
      for (int i = 0; i < N; i++)
        if (i != acc && !bus.req_valid[i] && $urandom_range(0, 3) == 0) new_req(i);
      if (cyc >= 2990) bus.req_valid = '0;
      drive_fields();
    end
    check("rnd_all_answered", 64'(inflight), 64'd0);
    check("rnd_resp_count", 64'(n_resp), 64'(n_acc));
    for (int i = 0; i < 4; i++)
      check($sformatf("rnd_rf%0d", i), 64'(rf[i]), 64'(model_rf[i]));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/regfile_bus_arbiter.md
Name: regfile_bus_arbiter

Overview:
- Sequences all transfers on the shared 16-bit register bus.
- Round-robin arbitrates up to NUM_REQ requesters and serialises each request into read and write phases, because the register file has one address port.
- Drives register_addr, bus_register_out_en and bus_register_input_en, and drives the bus itself during write phases.
- Sits between the control units and the 4-entry register file.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
DATA_WIDTH, 16, bus/register data width
ADDR_WIDTH, 6, register address width

Ports:
arbiter_clock  input  1  single clock; all state updates on rising edge
arbiter_reset  input  1  asynchronous, active-low reset
req_valid  input  NUM_REQ  request pending, one bit per requester; held until accepted
req_op  input  2*NUM_REQ  per-requester op: 00 MOVE src->dst, 01 LOAD imm->dst, 10 READ src, 11 reserved
req_src  input  ADDR_WIDTH*NUM_REQ  per-requester source register address
req_dst  input  ADDR_WIDTH*NUM_REQ  per-requester destination register address
req_imm  input  DATA_WIDTH*NUM_REQ  per-requester immediate for LOAD
req_ready  output  NUM_REQ  one-hot accept strobe; request fields sampled on this edge
resp_valid  output  NUM_REQ  one-hot, one-cycle completion pulse
resp_data  output  DATA_WIDTH  READ: register value; MOVE: moved value; LOAD: imm; reserved: 0
resp_err  output  1  high with resp_valid for reserved op
register_addr  output  ADDR_WIDTH  address to register file
bus_register_out_en  output  1  register file drives bus
bus_register_input_en  output  1  register file writes bus value at next edge
bus_data_in  input  DATA_WIDTH  bus value sampled during read phase
bus_data_out  output  DATA_WIDTH  value the arbiter drives onto the bus
bus_data_out_en  output  1  arbiter tri-state enable
busy  output  1  state != IDLE

Behaviour:
- States: IDLE, READ, WRITE, RESP. All outputs are decoded combinationally from registered state, grant index, latched request, and (in IDLE only) req_valid.
- Reset (arbiter_reset=0, asynchronous):
  - state=IDLE, rr_ptr=0, grant=0, hold=0, latched op/src/dst=0.
  - All enables, req_ready, resp_valid, resp_err, busy=0; register_addr=0; bus_data_out=0; resp_data=0.
- IDLE arbitration:
  - Scan req_valid starting at rr_ptr, wrapping modulo NUM_REQ; the first set bit is g.
  - req_ready[g]=1 in the same cycle; at the edge latch op/src/dst/imm of g, set rr_ptr=(g+1) mod NUM_REQ, and leave IDLE.
  - Next state by op: MOVE->READ, READ->READ, LOAD->WRITE (hold<=imm), reserved->RESP (hold<=0, err flag set).
  - No req_valid: stay in IDLE and drive nothing.
- READ: register_addr=src, bus_register_out_en=1, bus_data_out_en=0; hold<=bus_data_in at edge. Next state: MOVE->WRITE, READ->RESP.
- WRITE: register_addr=dst, bus_data_out=hold, bus_data_out_en=1, bus_register_input_en=1, bus_register_out_en=0. Next state: RESP.
- RESP: resp_valid[g]=1, resp_data=hold, resp_err=err flag. Next state: IDLE. resp_data holds its value until the next RESP.
- Latency, counted from the accept edge to the resp_valid cycle:
  - MOVE: READ, WRITE, RESP (resp in 3rd cycle).
  - READ and LOAD: resp in 2nd cycle.
  - Reserved op: resp in 1st cycle.
- Throughput: one request in flight; a new grant is possible in the cycle after RESP.
- Invariants:
  - bus_register_out_en and bus_data_out_en are never both 1.
  - bus_register_input_en implies bus_data_out_en.
  - At most one bit of req_ready and of resp_valid is set.
- Requests arriving while busy wait; req_valid changes outside IDLE are ignored.
- Addresses are passed through unchanged. Addresses >3 are not decoded by the register file: a write is dropped, and a read returns 0 (bus undriven; treat as 0 in sim).
- Reset mid-operation: enables drop immediately; no response is issued for the in-flight request. A write completes only if its WRITE-cycle edge occurred before reset asserted.
- Fairness: a requester holding req_valid is granted within NUM_REQ grants.

Test Plan:
- Reset then idle: arbiter_reset=0 mid-WRITE -> bus_register_input_en and bus_data_out_en fall without a clock edge; after release busy=0, rr_ptr=0, no resp_valid.
- LOAD: req 0 LOAD dst=2 imm=0xBEEF -> WRITE cycle drives addr=2, bus_data_out=0xBEEF, input_en=1; next cycle resp_valid=0001, resp_data=0xBEEF.
- MOVE: reg2=0xBEEF, req 1 MOVE src=2 dst=3 -> READ (addr=2, out_en=1), WRITE (addr=3, data=0xBEEF), resp_valid=0010, resp_data=0xBEEF; a subsequent READ src=3 returns 0xBEEF.
- Round-robin: req_valid=1111 held for 8 requests -> grant order 0,1,2,3,0,1,2,3; with rr_ptr=2 and req_valid=0011 -> grant 0.
- Reserved op: req 3 op=11 -> resp_valid=1000 on the cycle after accept, resp_err=1, resp_data=0, no bus enables asserted.
- Invariant check across random traffic: out_en and data_out_en never both 1; each accepted request yields exactly one resp_valid to the same index.
